// File: rtl/relu_quant_writer_if.sv
// relu_quant_writer_if: row stream from the bias/ReLU stage and the output
// SRAM write port of relu_quant_writer, bundled as one interface.
// slave  : the writer block (consumes rows, drives the SRAM port)
// master : the environment (produces rows, observes the SRAM port)
interface relu_quant_writer_if #(
    parameter int ARRAY_N    = 16,
    parameter int OUT_WIDTH  = 32,
    parameter int Q_WIDTH    = 8,
    parameter int ADDR_WIDTH = 10
);
    logic                          in_valid;
    logic                          in_ready;
    logic [ARRAY_N*OUT_WIDTH-1:0]  data_in;
    logic                          wr_en;
    logic [ADDR_WIDTH-1:0]         wr_addr;
    logic [ARRAY_N*Q_WIDTH-1:0]    wr_data;

    modport slave (
        input  in_valid,
        input  data_in,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport master (
        output in_valid,
        output data_in,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/relu_quant_writer.sv
// relu_quant_writer: requantizes rows of ARRAY_N signed OUT_WIDTH-bit lanes to
// unsigned Q_WIDTH-bit lanes (rounding right shift, unsigned saturation,
// negatives forced to zero) and writes each packed row to consecutive SRAM
// addresses. A three-state FSM (IDLE/RUN/DONE) runs a job of cfg_num_rows rows.
// Optional feature macro: RELU_QUANT_STATS_EN adds the sat_count output, the
// number of lanes clamped to 2^Q_WIDTH-1 in the current job.
module relu_quant_writer #(
    parameter int ARRAY_N    = 16,
    parameter int OUT_WIDTH  = 32,
    parameter int Q_WIDTH    = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [4:0]            cfg_shift,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [ADDR_WIDTH:0]   cfg_num_rows,
    relu_quant_writer_if.slave    io,
    output logic                  busy,
    output logic                  done
`ifdef RELU_QUANT_STATS_EN
    ,
    output logic [15:0]           sat_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Largest representable output lane, widened to the rounding width.
    localparam logic [OUT_WIDTH:0] Q_MAX =
        {{(OUT_WIDTH + 1 - Q_WIDTH){1'b0}}, {Q_WIDTH{1'b1}}};

    state_t                   state;
    state_t                   state_nxt;
    logic                     start_acc;

    logic [4:0]               shift_q;
    logic [ADDR_WIDTH-1:0]    base_q;
    logic [ADDR_WIDTH:0]      rows_q;
    logic [ADDR_WIDTH:0]      row_cnt;

    logic                     vld_p0;
    logic                     last_row_p0;
    logic [ADDR_WIDTH-1:0]    addr_p0;
    logic [ARRAY_N*Q_WIDTH-1:0] data_p0;

    logic                     vld_p1;
    logic [ADDR_WIDTH-1:0]    addr_p1;
    logic [ARRAY_N*Q_WIDTH-1:0] data_p1;

    // Add the half-LSB rounding constant and shift right. Done in one extra
    // bit so the largest positive input plus the rounding term cannot wrap.
    function automatic logic [OUT_WIDTH:0] round_shift(
        input logic signed [OUT_WIDTH-1:0] v,
        input logic [4:0]                  sh
    );
        logic [OUT_WIDTH:0] mag;
        logic [OUT_WIDTH:0] rnd;
        mag = {1'b0, v};
        rnd = '0;
        if (sh != 5'd0) begin
            rnd = (OUT_WIDTH + 1)'(1) << (sh - 5'd1);
        end
        return (mag + rnd) >> sh;
    endfunction

    // Clamp a non-negative rounded value into the unsigned output range.
    function automatic logic [Q_WIDTH-1:0] sat_u(input logic [OUT_WIDTH:0] r);
        if (r > Q_MAX) begin
            return {Q_WIDTH{1'b1}};
        end
        return r[Q_WIDTH-1:0];
    endfunction

    // Full per-lane requantization; negative lanes (never expected after
    // ReLU) are flushed to zero rather than wrapped.
    function automatic logic [Q_WIDTH-1:0] quant_lane(
        input logic signed [OUT_WIDTH-1:0] v,
        input logic [4:0]                  sh
    );
        if (v < 0) begin
            return '0;
        end
        return sat_u(round_shift(v, sh));
    endfunction

    // The row handshake and the address of the row being accepted.
    assign io.in_ready = (state == RUN);
    assign vld_p0      = io.in_valid && (state == RUN);
    assign last_row_p0 = (row_cnt == (rows_q - (ADDR_WIDTH + 1)'(1)));
    assign addr_p0     = base_q + row_cnt[ADDR_WIDTH-1:0];

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state and status outputs.
    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = (cfg_num_rows == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (vld_p0 && last_row_p0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Job configuration is captured once per accepted start and held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
            base_q  <= '0;
            rows_q  <= '0;
        end else if (start_acc) begin
            shift_q <= cfg_shift;
            base_q  <= cfg_base_addr;
            rows_q  <= cfg_num_rows;
        end
    end

    // Row counter: cleared on start, advanced on every accepted row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_cnt <= '0;
        end else if (start_acc) begin
            row_cnt <= '0;
        end else if (vld_p0) begin
            row_cnt <= row_cnt + (ADDR_WIDTH + 1)'(1);
        end
    end

    // ---- stage p0: requantize every lane of the incoming row ----
    // Lane-parallel requantization of the presented row.
    always_comb begin
        data_p0 = '0;
        for (int i = 0; i < ARRAY_N; i++) begin
            data_p0[Q_WIDTH*i +: Q_WIDTH] =
                quant_lane(io.data_in[OUT_WIDTH*i +: OUT_WIDTH], shift_q);
        end
    end

    // ---- stage p1: SRAM write port ----
    // Write strobe follows each handshake by one cycle; address/data hold
    // their last value between writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                addr_p1 <= addr_p0;
                data_p1 <= data_p0;
            end
        end
    end

    assign io.wr_en   = vld_p1;
    assign io.wr_addr = addr_p1;
    assign io.wr_data = data_p1;

`ifdef RELU_QUANT_STATS_EN
    localparam int CNT_W = $clog2(ARRAY_N + 1);

    logic [CNT_W-1:0] clamp_cnt_p0;

    // A lane counts as clamped only when its rounded value exceeded the
    // output range; an exact 2^Q_WIDTH-1 result is not a clamp.
    function automatic logic lane_clamps(
        input logic signed [OUT_WIDTH-1:0] v,
        input logic [4:0]                  sh
    );
        if (v < 0) begin
            return 1'b0;
        end
        return (round_shift(v, sh) > Q_MAX);
    endfunction

    // Saturating accumulate so the counter sticks at all-ones.
    function automatic logic [15:0] sat_add16(
        input logic [15:0]      acc,
        input logic [CNT_W-1:0] inc
    );
        logic [16:0] s;
        s = {1'b0, acc} + 17'(inc);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Popcount of clamped lanes in the presented row.
    always_comb begin
        clamp_cnt_p0 = '0;
        for (int i = 0; i < ARRAY_N; i++) begin
            clamp_cnt_p0 = clamp_cnt_p0 +
                CNT_W'(lane_clamps(io.data_in[OUT_WIDTH*i +: OUT_WIDTH], shift_q));
        end
    end

    // Per-job clamp counter, updated alongside the write of each row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_count <= '0;
        end else if (start_acc) begin
            sat_count <= '0;
        end else if (vld_p0) begin
            sat_count <= sat_add16(sat_count, clamp_cnt_p0);
        end
    end
`endif

endmodule

// File: tb/tb_relu_quant_writer.sv
// tb_relu_quant_writer: randomized scoreboard bench for relu_quant_writer.
// A driver issues jobs and rows and pushes the expected SRAM writes into a
// queue; an independent monitor pops and compares on every write strobe.
module tb_relu_quant_writer;
    localparam int N  = 16;
    localparam int OW = 32;
    localparam int QW = 8;
    localparam int AW = 10;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [N*QW-1:0] data;
        bit              last;
        int              sat;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [4:0]    cfg_shift;
    logic [AW-1:0] cfg_base_addr;
    logic [AW:0]   cfg_num_rows;
    logic          busy;
    logic          done;
`ifdef RELU_QUANT_STATS_EN
    logic [15:0]   sat_count;
`endif

    relu_quant_writer_if #(.ARRAY_N(N), .OUT_WIDTH(OW), .Q_WIDTH(QW), .ADDR_WIDTH(AW)) bus ();

    relu_quant_writer #(.ARRAY_N(N), .OUT_WIDTH(OW), .Q_WIDTH(QW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .cfg_shift    (cfg_shift),
        .cfg_base_addr(cfg_base_addr),
        .cfg_num_rows (cfg_num_rows),
        .io           (bus),
        .busy         (busy),
        .done         (done)
`ifdef RELU_QUANT_STATS_EN
        ,
        .sat_count    (sat_count)
`endif
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    int   exp_zero_done = 0;
    int   cur_base;
    int   cur_shift;
    int   job_sat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, got, want);
        end
    endtask

    // Reference requantization from the arithmetic definition.
    function automatic void ref_lane(input logic [31:0] raw, input int sh,
                                     output logic [7:0] q, output bit clamp);
        int    v;
        longint r;
        v = $signed(raw);
        clamp = 1'b0;
        if (v < 0) begin
            q = 8'd0;
        end else begin
            r = longint'(v);
            if (sh > 0) r = r + (longint'(1) << (sh - 1));
            r = r >> sh;
            if (r > 255) begin
                q = 8'd255;
                clamp = 1'b1;
            end else begin
                q = 8'(r);
            end
        end
    endfunction

    function automatic logic [31:0] rand_lane();
        case ($urandom_range(0, 4))
            0: return 32'($urandom);
            1: return 32'($urandom_range(0, 600));
            2: return 32'($urandom) >> $urandom_range(0, 31);
            3: return 32'(-$signed($urandom_range(1, 1000)));
            default: return 32'h7FFF_FFFF - 32'($urandom_range(0, 5));
        endcase
    endfunction

    // dmode 0: random lanes; 1: every lane 16*j+8; 2: {300,255,-7,0,0...}
    function automatic logic [N*OW-1:0] make_row(input int dmode, input int j);
        logic [N*OW-1:0] row;
        row = '0;
        for (int i = 0; i < N; i++) begin
            case (dmode)
                0: row[OW*i +: OW] = rand_lane();
                1: row[OW*i +: OW] = 32'(16 * j + 8);
                default: begin
                    case (i)
                        0: row[OW*i +: OW] = 32'd300;
                        1: row[OW*i +: OW] = 32'd255;
                        2: row[OW*i +: OW] = 32'hFFFF_FFF9;
                        default: row[OW*i +: OW] = 32'd0;
                    endcase
                end
            endcase
        end
        return row;
    endfunction

    task automatic start_job(input int base, input int rows, input int sh);
        @(negedge clk);
        chk("idle_before_start", 128'(busy), 128'(1'b0));
        start         = 1'b1;
        cfg_base_addr = AW'(base);
        cfg_num_rows  = (AW + 1)'(rows);
        cfg_shift     = 5'(sh);
        cur_base      = base;
        cur_shift     = sh;
        job_sat       = 0;
        if (rows == 0) exp_zero_done++;
    endtask

    // vmode 0: valid always; 1: pattern 1-0-1-1-0-1; 2: random 75%
    task automatic run_rows(input int n, input int dmode, input int vmode,
                            input int stop_after, input bit inject_start);
        int   acc;
        int   tick;
        int   cyc;
        bit   hs;
        bit   vld;
        logic [N*OW-1:0] row;
        exp_t e;
        logic [7:0] q;
        bit   cl;
        int   pat[6] = '{1, 0, 1, 1, 0, 1};
        acc  = 0;
        tick = 0;
        for (int j = 0; j < n; j++) begin
            if (acc == stop_after) break;
            row    = make_row(dmode, j);
            e.addr = AW'(cur_base + j);
            e.last = (j == n - 1);
            for (int i = 0; i < N; i++) begin
                ref_lane(row[OW*i +: OW], cur_shift, q, cl);
                e.data[QW*i +: QW] = q;
                if (cl) job_sat++;
            end
            e.sat = job_sat;
            exp_q.push_back(e);
            cyc = 0;
            do begin
                @(negedge clk);
                start         = inject_start && (tick == 1);
                cfg_shift     = 5'($urandom);
                cfg_base_addr = AW'($urandom);
                cfg_num_rows  = (AW + 1)'($urandom);
                case (vmode)
                    0: vld = 1'b1;
                    1: vld = (pat[tick % 6] != 0);
                    default: vld = ($urandom_range(0, 3) != 0);
                endcase
                bus.in_valid = vld;
                bus.data_in  = row;
                hs = vld && bus.in_ready;
                tick++;
                cyc++;
            end while (!hs && cyc < 50);
            if (!hs) begin
                n_checks++;
                n_fail++;
                $display("FAIL row_accept_timeout: got in_ready=0 for 50 cycles, required a handshake");
                exp_q.delete();
                return;
            end
            acc++;
        end
    endtask

    // Cycle after the last handshake is DONE, the one after that is IDLE.
    task automatic finish_job();
        @(negedge clk);
        bus.in_valid = 1'b0;
        start        = 1'b0;
        chk("done_after_last", 128'(done), 128'(1'b1));
        chk("ready_low_in_done", 128'(bus.in_ready), 128'(1'b0));
        @(negedge clk);
        chk("idle_after_done", 128'(busy), 128'(1'b0));
        chk("done_single_pulse", 128'(done), 128'(1'b0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 128'(bus.in_ready), 128'(0));
        chk({tag, "_wr_en"},    128'(bus.wr_en),    128'(0));
        chk({tag, "_wr_addr"},  128'(bus.wr_addr),  128'(0));
        chk({tag, "_wr_data"},  128'(bus.wr_data),  128'(0));
        chk({tag, "_busy"},     128'(busy),         128'(0));
        chk({tag, "_done"},     128'(done),         128'(0));
`ifdef RELU_QUANT_STATS_EN
        chk({tag, "_sat_count"}, 128'(sat_count),   128'(0));
`endif
    endtask

    // Monitor: every write strobe must match the oldest expected row.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (bus.wr_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got wr_en=1 addr %0h, required no write", bus.wr_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 128'(bus.wr_addr), 128'(e.addr));
                    chk("wr_data", 128'(bus.wr_data), 128'(e.data));
                    chk("done_with_write", 128'(done), 128'(e.last));
`ifdef RELU_QUANT_STATS_EN
                    chk("sat_count", 128'(sat_count), 128'(e.sat));
`endif
                end
            end else if (done) begin
                if (exp_zero_done > 0) begin
                    exp_zero_done--;
                    chk("zero_row_done_no_write", 128'(bus.wr_en), 128'(0));
                end else begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_done: got done=1 without write, required 0");
                end
            end
        end
    end

    initial begin
        reset_n       = 1'b0;
        start         = 1'b0;
        cfg_shift     = '0;
        cfg_base_addr = '0;
        cfg_num_rows  = '0;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;

        // Reset and idle behaviour.
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.data_in  = make_row(0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("idle_in_ready", 128'(bus.in_ready), 128'(0));
            chk("idle_wr_en", 128'(bus.wr_en), 128'(0));
        end
        bus.in_valid = 1'b0;

        // Basic job: lanes (16j+8)/16 rounded -> 1, 2, 3 at addresses 5..7.
        start_job(5, 3, 4);
        run_rows(3, 1, 0, 1000, 1'b0);
        finish_job();

        // Saturation and negative input at shift 0.
        start_job(100, 1, 0);
        run_rows(1, 2, 0, 1000, 1'b0);
        finish_job();

        // Stalls, address wrap and an ignored mid-job start.
        start_job(1022, 4, 3);
        run_rows(4, 0, 1, 1000, 1'b1);
        finish_job();

        // Zero-row job, then a start at the earliest legal cycle.
        start_job(20, 0, 3);
        @(negedge clk);
        start = 1'b0;
        chk("zero_rows_done", 128'(done), 128'(1'b1));
        chk("zero_rows_busy", 128'(busy), 128'(1'b1));
        chk("zero_rows_ready", 128'(bus.in_ready), 128'(1'b0));
        start_job(40, 1, 1);
        run_rows(1, 0, 0, 1000, 1'b0);
        finish_job();

        // Reset mid-job after 2 of 8 rows.
        start_job(300, 8, 2);
        run_rows(8, 0, 0, 2, 1'b0);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        start = 1'b0;
        exp_q.delete();
        #1;
        chk_reset_outputs("midjob_reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        start_job(1000, 5, 5);
        run_rows(5, 0, 2, 1000, 1'b0);
        finish_job();

        // Random jobs.
        for (int k = 0; k < 8; k++) begin
            int rows;
            rows = int'($urandom_range(1, 6));
            start_job(int'($urandom_range(0, 1023)), rows, int'($urandom_range(0, 31)));
            run_rows(rows, 0, 2, 1000, 1'($urandom_range(0, 1)));
            finish_job();
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        chk("zero_done_drained", 128'(exp_zero_done), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
